// File: rtl/gpu_pkg.sv
// gpu_pkg: definitions shared by the GPU instruction scheduler and its testbench.
//   - Coordinate and colour widths used on every instruction field.
//   - Opcode values, engine index constants and the scheduler FSM state enum.
//   - instr_t packed struct that carries one complete instruction.
//   - sat_inc16 helper for the saturating completed-instruction counter.
package gpu_pkg;

  localparam int WIDTH_BITS   = 10;
  localparam int HEIGHT_BITS  = 9;
  localparam int CHANNEL_BITS = 8;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_RECT   = 4'h1;
  localparam logic [3:0] OP_CIRCLE = 4'h2;
  localparam logic [3:0] OP_ARC    = 4'h3;
  localparam logic [3:0] OP_LINE   = 4'h4;

  localparam logic [1:0] ENG_LINE   = 2'd0;
  localparam logic [1:0] ENG_CIRCLE = 2'd1;
  localparam logic [1:0] ENG_ARC    = 2'd2;
  localparam logic [1:0] ENG_RECT   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_DISPATCH = 3'd3,
    ST_WAIT     = 3'd4
  } sched_state_t;

  typedef struct packed {
    logic [3:0]              opcode;
    logic [WIDTH_BITS-1:0]   x1;
    logic [HEIGHT_BITS-1:0]  y1;
    logic [WIDTH_BITS-1:0]   x2;
    logic [HEIGHT_BITS-1:0]  y2;
    logic [WIDTH_BITS-1:0]   rad;
    logic [CHANNEL_BITS-1:0] r;
    logic [CHANNEL_BITS-1:0] g;
    logic [CHANNEL_BITS-1:0] b;
    logic [2:0]              quad;
  } instr_t;

  // Counts up and sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/gpu_opcode_decoder.sv
// gpu_opcode_decoder: purely combinational opcode classifier.
// Ports:
//   opcode  in  4  registered instruction opcode
//   valid   out 1  opcode is defined (NOP included)
//   nop     out 1  opcode is NOP (no engine involved)
//   engine  out 2  target engine index, meaningful when valid && !nop
module gpu_opcode_decoder
  import gpu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       valid,
  output logic       nop,
  output logic [1:0] engine
);

  always_comb begin
    valid  = 1'b1;
    nop    = 1'b0;
    engine = ENG_LINE;
    case (opcode)
      OP_NOP:    nop    = 1'b1;
      OP_RECT:   engine = ENG_RECT;
      OP_CIRCLE: engine = ENG_CIRCLE;
      OP_ARC:    engine = ENG_ARC;
      OP_LINE:   engine = ENG_LINE;
      default:   valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/gpu_instruction_scheduler.sv
// gpu_instruction_scheduler: pops instructions from the instruction FIFO one at
// a time, hands each to its draw engine and waits for completion or a watchdog
// abort before fetching the next one.
// Ports:
//   clk, n_rst                       clock, asynchronous active-low reset
//   fifo_empty_i                     FIFO empty flag; head fields valid when low
//   opcode_i .. quad_i               FIFO head instruction fields
//   halt_i                           blocks new fetches (looked at in IDLE only)
//   engine_ready_i / engine_done_i   per-engine ready level / done pulse
//   pop_instruction_o                one-cycle FIFO pop per fetch
//   engine_start_o                   one-hot start pulse
//   opcode_o .. quad_o               registered instruction broadcast to engines
//   busy_o                           FSM not in IDLE
//   illegal_op_o, timeout_o          one-cycle event pulses
//   instr_count_o                    saturating completed-instruction count
//   state_o                          current FSM state (debug visibility)
//
// Handshake: an engine transfer happens in the cycle where the scheduler is in
// DISPATCH and engine_ready_i[sel] is high; engine_start_o[sel] is that
// condition itself, so a start is never raised against a low ready and the FSM
// never leaves DISPATCH without a start. Completion is the single-cycle
// engine_done_i[sel] pulse; done bits of other engines are ignored.
module gpu_instruction_scheduler
  import gpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    fifo_empty_i,
  input  logic [3:0]              opcode_i,
  input  logic [WIDTH_BITS-1:0]   x1_i,
  input  logic [HEIGHT_BITS-1:0]  y1_i,
  input  logic [WIDTH_BITS-1:0]   x2_i,
  input  logic [HEIGHT_BITS-1:0]  y2_i,
  input  logic [WIDTH_BITS-1:0]   rad_i,
  input  logic [CHANNEL_BITS-1:0] r_i,
  input  logic [CHANNEL_BITS-1:0] g_i,
  input  logic [CHANNEL_BITS-1:0] b_i,
  input  logic [2:0]              quad_i,
  input  logic                    halt_i,
  input  logic [3:0]              engine_ready_i,
  input  logic [3:0]              engine_done_i,
  output logic                    pop_instruction_o,
  output logic [3:0]              engine_start_o,
  output logic [3:0]              opcode_o,
  output logic [WIDTH_BITS-1:0]   x1_o,
  output logic [HEIGHT_BITS-1:0]  y1_o,
  output logic [WIDTH_BITS-1:0]   x2_o,
  output logic [HEIGHT_BITS-1:0]  y2_o,
  output logic [WIDTH_BITS-1:0]   rad_o,
  output logic [CHANNEL_BITS-1:0] r_o,
  output logic [CHANNEL_BITS-1:0] g_o,
  output logic [CHANNEL_BITS-1:0] b_o,
  output logic [2:0]              quad_o,
  output logic                    busy_o,
  output logic                    illegal_op_o,
  output logic                    timeout_o,
  output logic [15:0]             instr_count_o,
  output logic [2:0]              state_o
);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  sched_state_t state;
  instr_t       head;
  instr_t       instr_q;
  logic [1:0]   eng_sel;
  logic [15:0]  watchdog;
  logic [15:0]  count;

  logic         dec_valid;
  logic         dec_nop;
  logic [1:0]   dec_engine;
  logic         sel_ready;
  logic         sel_done;
  logic         wd_expired;

  assign head = '{opcode: opcode_i, x1: x1_i, y1: y1_i, x2: x2_i, y2: y2_i,
                  rad: rad_i, r: r_i, g: g_i, b: b_i, quad: quad_i};

  // Decode works on the captured copy, so the FIFO head may change after pop.
  gpu_opcode_decoder u_decoder (
    .opcode (instr_q.opcode),
    .valid  (dec_valid),
    .nop    (dec_nop),
    .engine (dec_engine)
  );

  assign sel_ready  = engine_ready_i[eng_sel];
  assign sel_done   = engine_done_i[eng_sel];
  // watchdog holds the number of WAIT cycles elapsed including the current one.
  assign wd_expired = (watchdog == TIMEOUT_LIMIT);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= ST_IDLE;
      instr_q  <= '0;
      eng_sel  <= ENG_LINE;
      watchdog <= '0;
      count    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty_i && !halt_i) state <= ST_FETCH;
        end
        ST_FETCH: begin
          instr_q <= head;
          state   <= ST_DECODE;
        end
        ST_DECODE: begin
          if (dec_nop) begin
            count <= sat_inc16(count);
            state <= ST_IDLE;
          end else if (!dec_valid) begin
            state <= ST_IDLE;
          end else begin
            eng_sel <= dec_engine;
            state   <= ST_DISPATCH;
          end
        end
        ST_DISPATCH: begin
          // An engine that is not ready stalls here indefinitely; the watchdog
          // only guards the wait for done.
          if (sel_ready) begin
            watchdog <= 16'd1;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Done is checked first so a done on the expiry cycle still counts.
          if (sel_done) begin
            count <= sat_inc16(count);
            state <= ST_IDLE;
          end else if (wd_expired) begin
            state <= ST_IDLE;
          end else begin
            watchdog <= watchdog + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Decoded straight from state so reset drops pop and start without a clock.
  always_comb begin
    engine_start_o = '0;
    if (state == ST_DISPATCH && sel_ready) engine_start_o[eng_sel] = 1'b1;
  end

  assign pop_instruction_o = (state == ST_FETCH);
  assign busy_o            = (state != ST_IDLE);
  assign illegal_op_o      = (state == ST_DECODE) && !dec_valid;
  assign timeout_o         = (state == ST_WAIT) && wd_expired && !sel_done;
  assign instr_count_o     = count;
  assign state_o           = state;

  assign opcode_o = instr_q.opcode;
  assign x1_o     = instr_q.x1;
  assign y1_o     = instr_q.y1;
  assign x2_o     = instr_q.x2;
  assign y2_o     = instr_q.y2;
  assign rad_o    = instr_q.rad;
  assign r_o      = instr_q.r;
  assign g_o      = instr_q.g;
  assign b_o      = instr_q.b;
  assign quad_o   = instr_q.quad;

endmodule
